// File: rtl/uart_tx_fifo_if.sv
// Byte write channel into the UART transmit FIFO (valid/ready).
interface uart_tx_fifo_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO: buffers bytes and sends them as 8N1 frames,
// LSB first, back to back while the FIFO holds data.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_fifo_if.slave               wr,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] head;
  logic       push;
  logic       pop;
  logic       baud_end;

  assign head     = mem_q[rd_ptr_q];
  assign push     = wr.tx_valid && ready_q;
  assign baud_end = (baud_q == BAUD_LAST);

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr.tx_data;
  end

  // Frame sequencer: next state, bit timing, shift register and line level
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BAUD_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is waiting
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase

`ifdef UART_TX_PARITY_EN
    if (pop) parity_d = ^head;
`endif

    // Line level follows the state being entered so tx stays a pure flop
    tx_d = 1'b1;
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy and registered status outputs
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < CNT_FULL);
    busy_d  = (state_d != S_IDLE) || (count_d != '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign wr.tx_ready = ready_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_tx_fifo;

  localparam int unsigned CLKS  = 4;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int FB = int'(NBITS * CLKS);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_fifo_if wr();

  uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // frame bit i = line level during bit slot i (slot 0 = start, 9 = stop)
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t       tbl [9];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] wr_bytes  [8];
  logic [9:0] exp_frame [8];
  logic       exp_par   [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input int f, input int slot);
    if (slot < 9) return exp_frame[f][slot];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return exp_par[f];
    return 1'b1;
`else
    return exp_frame[f][9];
`endif
  endfunction

  // Writes wr_bytes[0..n-1] (holding each until accepted) into an idle DUT and
  // checks the line every cycle against n contiguous frames, then idle.
  task automatic run_seq(input int n, input int exp_max);
    int acc = 0;
    int first = -1;
    int max_cnt = 0;
    bit done = 1'b0;
    bit acc_now;
    int s;
    @(negedge clk);
    wr.tx_valid = 1'b1;
    wr.tx_data  = wr_bytes[0];
    for (int c = 0; c < 2000 && !done; c++) begin
      acc_now = wr.tx_valid && wr.tx_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc_now) begin
        if (first < 0) first = c;
        acc++;
      end
      if (acc < n) begin
        wr.tx_valid = 1'b1;
        wr.tx_data  = wr_bytes[acc];
      end else begin
        wr.tx_valid = 1'b0;
        wr.tx_data  = 8'h00;
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      chk("tx_ready vs count", 32'(wr.tx_ready), 32'(int'(fifo_count) < int'(DEPTH)));
      if (first >= 0) begin
        s = c - first - 1;
        if (s >= 0 && s < n * FB) begin
          chk($sformatf("tx frame%0d slot%0d cyc%0d", s / FB, (s % FB) / int'(CLKS), s % int'(CLKS)),
              32'(tx), 32'(exp_bit(s / FB, (s % FB) / int'(CLKS))));
          chk("busy in frame", 32'(busy), 32'd1);
        end else if (s == n * FB) begin
          chk("end tx idle", 32'(tx), 32'd1);
          chk("end busy", 32'(busy), 32'd0);
          chk("end fifo_count", 32'(fifo_count), 32'd0);
          chk("end tx_ready", 32'(wr.tx_ready), 32'd1);
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL run_seq timeout: accepted %0d of %0d", acc, n);
    end
    chk("bytes accepted", 32'(acc), 32'(n));
    chk("max fifo_count", 32'(max_cnt), 32'(exp_max));
  endtask

  initial begin
    wr.tx_valid = 1'b0;
    wr.tx_data  = 8'h00;
    rst_n       = 1'b0;

    tbl[0] = '{8'h55, 10'b1010101010, 1'b0};
    tbl[1] = '{8'hA3, 10'b1101000110, 1'b0};
    tbl[2] = '{8'h0F, 10'b1000011110, 1'b0};
    tbl[3] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[4] = '{8'h07, 10'b1000001110, 1'b1};
    tbl[5] = '{8'h03, 10'b1000000110, 1'b0};
    tbl[6] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[7] = '{8'h80, 10'b1100000000, 1'b1};
    tbl[8] = '{8'hD6, 10'b1110101100, 1'b1};

    // Reset values, during and after reset
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst tx_ready", 32'(wr.tx_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst fifo_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("post-rst {tx,ready,busy,count}", 32'({tx, wr.tx_ready, busy, fifo_count}), 32'(6'b110000));
    end

    // Single frames from the vector table
    for (int i = 0; i < 9; i++) begin
      wr_bytes[0]  = tbl[i].data;
      exp_frame[0] = tbl[i].frame;
      exp_par[0]   = tbl[i].par;
      run_seq(1, 1);
    end

    // Back-to-back writes give contiguous frames
    wr_bytes[0] = 8'hA3; exp_frame[0] = 10'b1101000110; exp_par[0] = 1'b0;
    wr_bytes[1] = 8'h0F; exp_frame[1] = 10'b1000011110; exp_par[1] = 1'b0;
    run_seq(2, 1);

    // Fill the FIFO with a continuously offered incrementing byte stream
    for (int k = 0; k < 6; k++) begin
      wr_bytes[k]  = 8'h10 + 8'(k);
      exp_frame[k] = {1'b1, wr_bytes[k], 1'b0};
      exp_par[k]   = ^wr_bytes[k];
    end
    run_seq(6, 4);

    // Reset during data bit 3 of 0xFF with a second byte queued
    @(negedge clk);
    wr.tx_valid = 1'b1;
    wr.tx_data  = 8'hFF;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    wr.tx_valid = 1'b0;
    repeat (17) begin @(posedge clk); @(negedge clk); end
    chk("pre-rst data bit3", 32'(tx), 32'd1);
    chk("pre-rst fifo_count", 32'(fifo_count), 32'd1);
    chk("pre-rst busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst tx", 32'(tx), 32'd1);
    chk("async rst fifo_count", 32'(fifo_count), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst tx_ready", 32'(wr.tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("after mid-frame rst {tx,busy,count}", 32'({tx, busy, fifo_count}), 32'(5'b10000));
    end

    // Reset while the start bit is low: line must rise without a clock
    wr.tx_valid = 1'b1;
    wr.tx_data  = 8'h00;
    @(posedge clk); @(negedge clk);
    wr.tx_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("start bit low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async rst in start bit", 32'(tx), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("after start-bit rst tx", 32'(tx), 32'd1);
    end

    // Normal operation resumes after reset
    wr_bytes[0]  = tbl[0].data;
    exp_frame[0] = tbl[0].frame;
    exp_par[0]   = tbl[0].par;
    run_seq(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
